mips_pipeline_memwb_writeback: RTL and testbench
================================================

Name: mips_pipeline_memwb_writeback

Overview:
- Consumer end of the MEM/WB interface.
- Latches the MEM/WB pipeline fields produced by the MEM stage, selects the writeback value, and commits it to the 32x32 general register file.
- Serves two asynchronous register read ports to ID with write-through bypass.
- Exports the WB destination and value for EX forwarding, plus a retired-instruction counter.

Parameters:
- WORD, 32, data/address width
- REGS, 32, register count (index width = log2(REGS) = 5)
- CNT_W, 32, retire counter width

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- stall  input  1  hold MEM/WB latch contents; no commit while high
- flush  input  1  load a bubble into the latch (valid=0)
- in_valid  input  1  MEM stage holds a real instruction
- in_regWrite  input  1  instruction writes a register
- in_wbSel  input  2  writeback source: 0=ALU result, 1=memory data, 2=PC+8 (link), 3=reserved (treated as 0)
- in_writeReg  input  5  destination register index
- in_aluOut  input  WORD  ALU result
- in_memOut  input  WORD  data-memory read value
- in_pc  input  WORD  instruction address
- rs_addr, rt_addr  input  5 each  ID read indices
- rs_data, rt_data  output  WORD each  ID read data
- wb_en  output  1  a register write is committing this cycle
- wb_reg  output  5  committing destination
- wb_data  output  WORD  committing value
- retired  output  CNT_W  count of committed valid instructions

Behaviour:
- Latch: on each rising edge with reset_n=1:
  - flush=1 -> latch valid=0, other fields don't-care (flush wins over stall).
  - else stall=1 -> hold all latch fields.
  - else load all in_* fields.
- Reset: when reset_n=0 at an edge:
  - latch valid=0, all latch fields 0, all register-file entries 0, retired=0.
  - wb_en=0, wb_reg=0, wb_data=0 in the following cycle.
  - Reset mid-operation discards the latched instruction; no commit occurs on the reset edge.
- Writeback select is combinational from the latch:
  - wbSel=0 -> aluOut.
  - wbSel=1 -> memOut.
  - wbSel=2 -> pc+8, modulo 2^WORD.
  - wbSel=3 -> aluOut.
- wb_en = latch.valid & latch.regWrite & (latch.writeReg != 0) & ~stall.
- wb_reg and wb_data are driven from the latch every cycle. They are 0 when latch.valid=0.
- Register file commit:
  - On a rising edge with wb_en=1, regs[wb_reg] <= wb_data.
  - Commit happens on the same edge that advances the latch, so an instruction commits exactly once even under multi-cycle stall. A stalled instruction commits on the edge that releases the stall.
- r0: always reads 0, never written; a write to index 0 produces wb_en=0.
- Read ports are combinational:
  - rs_data = (rs_addr==0) ? 0 : (wb_en && wb_reg==rs_addr) ? wb_data : regs[rs_addr].
  - rt_data follows the same rule with rt_addr.
  - Bypass gives same-cycle write-then-read semantics.
- Retire counter:
  - retired increments by 1 on every edge where latch.valid=1 and stall=0, whether or not the instruction writes a register.
  - It wraps from 2^CNT_W-1 to 0.
- Latency: MEM fields to committed register value = 1 edge into latch + 1 edge commit. Visible via bypass 1 edge after the MEM-stage edge.
- Simultaneous stall and flush: flush applies; the latched instruction is dropped without commit.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> retired=0, wb_en=0, rs_data=rt_data=0 for every index.
- ALU write and bypass: load valid=1, regWrite=1, wbSel=0, writeReg=5, aluOut=0x1234 -> next cycle wb_en=1, wb_reg=5, and rs_addr=5 reads 0x1234 before commit. The cycle after, reading r5 returns 0x1234 from the file; retired=1.
- Load, link and r0: wbSel=1, memOut=0xDEADBEEF, reg 8 -> r8=0xDEADBEEF. Then wbSel=2, pc=0x00400010, reg 31 -> r31=0x00400018. Then write 0xFFFF to reg 0 -> wb_en=0, r0 reads 0.
- Stall: stall=1 for 3 cycles with a valid write of 0x55 to r3 latched -> wb_en=0 and retired unchanged during the stall. After release, exactly one commit, r3=0x55, retired +1.
- Flush and stall+flush together: latched write to r4 and flush=1 (also with stall=1) -> latch valid=0, r4 unchanged, retired unchanged.
- Counter wrap: CNT_W=4, issue 17 valid instructions without stall -> retired sequence reaches 15, wraps to 0, ends at 1.

Source files
------------

// File: rtl/mips_pipeline_memwb_writeback.sv
// MEM/WB latch, writeback select, 32x32 register file with write-through read bypass, retire counter.
// Latency: 1 edge into latch, commit on the next advancing edge; stall holds the latch and blocks commit.
module mips_pipeline_memwb_writeback #(
    parameter int WORD  = 32,
    parameter int REGS  = 32,
    parameter int CNT_W = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  logic                     in_regWrite_i,
    input  logic [1:0]               in_wbSel_i,
    input  logic [$clog2(REGS)-1:0]  in_writeReg_i,
    input  logic [WORD-1:0]          in_aluOut_i,
    input  logic [WORD-1:0]          in_memOut_i,
    input  logic [WORD-1:0]          in_pc_i,
    input  logic [$clog2(REGS)-1:0]  rs_addr_i,
    input  logic [$clog2(REGS)-1:0]  rt_addr_i,
    output logic [WORD-1:0]          rs_data_o,
    output logic [WORD-1:0]          rt_data_o,
    output logic                     wb_en_o,
    output logic [$clog2(REGS)-1:0]  wb_reg_o,
    output logic [WORD-1:0]          wb_data_o,
    output logic [CNT_W-1:0]         retired_o
);
    localparam int IDX_W = $clog2(REGS);

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [1:0]       wb_sel;
        logic [IDX_W-1:0] write_reg;
        logic [WORD-1:0]  alu_out;
        logic [WORD-1:0]  mem_out;
        logic [WORD-1:0]  pc;
    } memwb_t;

    memwb_t           latch_q, latch_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [WORD-1:0]  regs_q [REGS];
    logic [WORD-1:0]  sel_val;
    logic             advance;

    assign advance = latch_q.valid & ~stall_i;

    // Flush beats stall: the held instruction is dropped, not committed.
    always_comb begin
        latch_d = latch_q;
        if (flush_i) begin
            latch_d = '0;
        end else if (!stall_i) begin
            latch_d.valid     = in_valid_i;
            latch_d.reg_write = in_regWrite_i;
            latch_d.wb_sel    = in_wbSel_i;
            latch_d.write_reg = in_writeReg_i;
            latch_d.alu_out   = in_aluOut_i;
            latch_d.mem_out   = in_memOut_i;
            latch_d.pc        = in_pc_i;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (advance) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        case (latch_q.wb_sel)
            2'd1:    sel_val = latch_q.mem_out;
            2'd2:    sel_val = latch_q.pc + WORD'(8);
            default: sel_val = latch_q.alu_out;
        endcase
    end

    assign wb_en_o   = advance & latch_q.reg_write & (latch_q.write_reg != '0);
    assign wb_reg_o  = latch_q.valid ? latch_q.write_reg : '0;
    assign wb_data_o = latch_q.valid ? sel_val : '0;
    assign retired_o = retired_q;

    always_comb begin
        rs_data_o = regs_q[rs_addr_i];
        if (rs_addr_i == '0) begin
            rs_data_o = '0;
        end else if (wb_en_o && (wb_reg_o == rs_addr_i)) begin
            rs_data_o = wb_data_o;
        end
    end

    always_comb begin
        rt_data_o = regs_q[rt_addr_i];
        if (rt_addr_i == '0) begin
            rt_data_o = '0;
        end else if (wb_en_o && (wb_reg_o == rt_addr_i)) begin
            rt_data_o = wb_data_o;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            latch_q   <= '0;
            retired_q <= '0;
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            latch_q   <= latch_d;
            retired_q <= retired_d;
            if (wb_en_o) begin
                regs_q[wb_reg_o] <= wb_data_o;
            end
        end
    end
endmodule

// File: tb/tb_mips_pipeline_memwb_writeback.sv
// Randomized and directed bench for the MEM/WB writeback stage against a behavioural model.
module tb_mips_pipeline_memwb_writeback;
    logic        clock = 1'b0;
    logic        reset_n, stall, flush;
    logic        in_valid, in_regWrite;
    logic [1:0]  in_wbSel;
    logic [4:0]  in_writeReg, rs_addr, rt_addr;
    logic [31:0] in_aluOut, in_memOut, in_pc;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] retired;
    logic [31:0] rs_data_s, rt_data_s, wb_data_s;
    logic        wb_en_s;
    logic [4:0]  wb_reg_s;
    logic [3:0]  retired_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  wr;
        logic [31:0] alu, mem, pc;
    } instr_t;

    instr_t      m_lat;
    logic [31:0] m_regs [32];
    logic [31:0] m_ret;

    always #5 clock = ~clock;

    mips_pipeline_memwb_writeback #(.WORD(32), .REGS(32), .CNT_W(32)) dut (
        .clock_i(clock), .reset_n_i(reset_n), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_regWrite_i(in_regWrite), .in_wbSel_i(in_wbSel),
        .in_writeReg_i(in_writeReg), .in_aluOut_i(in_aluOut), .in_memOut_i(in_memOut),
        .in_pc_i(in_pc), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_data), .rt_data_o(rt_data), .wb_en_o(wb_en),
        .wb_reg_o(wb_reg), .wb_data_o(wb_data), .retired_o(retired)
    );

    mips_pipeline_memwb_writeback #(.WORD(32), .REGS(32), .CNT_W(4)) dut_s (
        .clock_i(clock), .reset_n_i(reset_n), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_regWrite_i(in_regWrite), .in_wbSel_i(in_wbSel),
        .in_writeReg_i(in_writeReg), .in_aluOut_i(in_aluOut), .in_memOut_i(in_memOut),
        .in_pc_i(in_pc), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_data_s), .rt_data_o(rt_data_s), .wb_en_o(wb_en_s),
        .wb_reg_o(wb_reg_s), .wb_data_o(wb_data_s), .retired_o(retired_s)
    );

    function automatic logic [31:0] m_value();
        case (m_lat.sel)
            2'd1:    return m_lat.mem;
            2'd2:    return m_lat.pc + 32'd8;
            default: return m_lat.alu;
        endcase
    endfunction

    function automatic logic m_en();
        return m_lat.valid && m_lat.rw && (m_lat.wr != 5'd0) && !stall;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_en() && m_lat.wr == a) return m_value();
        return m_regs[a];
    endfunction

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        in_valid = v; in_regWrite = rw; in_wbSel = sel; in_writeReg = wr;
        in_aluOut = alu; in_memOut = mem; in_pc = pc;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Advance the model by the rules of one clock edge, then let the DUT take the same edge.
    task automatic tick();
        if (!reset_n) begin
            m_lat = '{valid: 1'b0, rw: 1'b0, sel: 2'd0, wr: 5'd0, alu: 32'd0, mem: 32'd0, pc: 32'd0};
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_ret = 32'd0;
        end else begin
            if (m_en()) m_regs[m_lat.wr] = m_value();
            if (m_lat.valid && !stall) m_ret = m_ret + 32'd1;
            if (flush) m_lat.valid = 1'b0;
            else if (!stall)
                m_lat = '{valid: in_valid, rw: in_regWrite, sel: in_wbSel, wr: in_writeReg,
                          alu: in_aluOut, mem: in_memOut, pc: in_pc};
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 5'd7, 32'hAAAA_5555, 32'h1, 32'h2);
        tick();
        tick();
        reset_n = 1'b1;
        bubble();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %h want 0", retired); end
        checks++; if (retired_s !== 4'd0) begin errors++; $display("FAIL reset_retired_s got %h want 0", retired_s); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
        checks++; if (wb_reg !== 5'd0 || wb_data !== 32'd0) begin
            errors++; $display("FAIL reset_wb got reg %0d data %h want 0/0", wb_reg, wb_data); end
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
            checks++; if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
                errors++; $display("FAIL reset_read idx %0d got rs %h rt %h want 0", i, rs_data, rt_data); end
        end
    endtask

    task automatic test_alu_bypass();
        drive(1'b1, 1'b1, 2'd0, 5'd5, 32'h1234, 32'hFFFF_0000, 32'h100);
        tick();
        bubble(); rs_addr = 5'd5; rt_addr = 5'd0; #1;
        checks++; if (wb_en !== 1'b1 || wb_reg !== 5'd5) begin
            errors++; $display("FAIL alu_wb got en %b reg %0d want 1/5", wb_en, wb_reg); end
        checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL alu_bypass got %h want 1234", rs_data); end
        checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL alu_r0 got %h want 0", rt_data); end
        tick();
        checks++; if (rs_data !== 32'h1234 || wb_en !== 1'b0) begin
            errors++; $display("FAIL alu_file got %h en %b want 1234/0", rs_data, wb_en); end
        checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired got %0d want 1", retired); end
    endtask

    task automatic test_load_link_r0();
        drive(1'b1, 1'b1, 2'd1, 5'd8, 32'h1111, 32'hDEADBEEF, 32'h200);
        tick();
        drive(1'b1, 1'b1, 2'd2, 5'd31, 32'h2222, 32'h3333, 32'h00400010);
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd0, 32'hFFFF, 32'h0, 32'h0);
        rs_addr = 5'd31; #1;
        checks++; if (rs_data !== 32'h00400018) begin errors++; $display("FAIL link_bypass got %h want 00400018", rs_data); end
        tick();
        bubble(); rs_addr = 5'd0; #1;
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL r0_wb_en got %b want 0", wb_en); end
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_read got %h want 0", rs_data); end
        tick();
        rs_addr = 5'd8; rt_addr = 5'd31; #1;
        checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_r8 got %h want deadbeef", rs_data); end
        checks++; if (rt_data !== 32'h00400018) begin errors++; $display("FAIL link_r31 got %h want 00400018", rt_data); end
        checks++; if (retired !== 32'd4) begin errors++; $display("FAIL llr_retired got %0d want 4", retired); end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 2'd0, 5'd3, 32'h55, 32'h0, 32'h0);
        tick();
        bubble(); stall = 1'b1; rs_addr = 5'd3; #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (wb_en !== 1'b0 || rs_data !== 32'd0) begin
                errors++; $display("FAIL stall_hold cyc %0d got en %b r3 %h want 0/0", c, wb_en, rs_data); end
            checks++; if (retired !== 32'd4) begin errors++; $display("FAIL stall_retired cyc %0d got %0d want 4", c, retired); end
            tick();
        end
        stall = 1'b0; #1;
        checks++; if (wb_en !== 1'b1 || rs_data !== 32'h55) begin
            errors++; $display("FAIL stall_release got en %b r3 %h want 1/55", wb_en, rs_data); end
        tick();
        checks++; if (wb_en !== 1'b0 || rs_data !== 32'h55) begin
            errors++; $display("FAIL stall_commit got en %b r3 %h want 0/55", wb_en, rs_data); end
        checks++; if (retired !== 32'd5) begin errors++; $display("FAIL stall_retired_end got %0d want 5", retired); end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 2'd0, 5'd4, 32'h77, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0; bubble(); rs_addr = 5'd4; #1;
        checks++; if (wb_en !== 1'b0 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
            errors++; $display("FAIL flush_bubble got en %b reg %0d data %h want 0", wb_en, wb_reg, wb_data); end
        drive(1'b1, 1'b1, 2'd0, 5'd4, 32'h99, 32'h0, 32'h0);
        tick();
        bubble(); stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0; #1;
        checks++; if (wb_en !== 1'b0 || wb_reg !== 5'd0) begin
            errors++; $display("FAIL stallflush_latch got en %b reg %0d want 0/0", wb_en, wb_reg); end
        tick();
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL flush_r4 got %h want 0", rs_data); end
        checks++; if (retired !== 32'd5) begin errors++; $display("FAIL flush_retired got %0d want 5", retired); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            wr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0), 2'($urandom), wr,
                  $urandom, $urandom, $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rs_addr = 5'($urandom); rt_addr = ($urandom_range(0, 2) == 0) ? m_lat.wr : 5'($urandom);
            #1;
            checks++; if (wb_en !== m_en() || wb_en_s !== m_en()) begin
                errors++; $display("FAIL rnd_wb_en n %0d got %b/%b want %b", n, wb_en, wb_en_s, m_en()); end
            checks++; if (wb_reg !== (m_lat.valid ? m_lat.wr : 5'd0) || wb_reg_s !== wb_reg) begin
                errors++; $display("FAIL rnd_wb_reg n %0d got %0d/%0d", n, wb_reg, wb_reg_s); end
            checks++; if (wb_data !== (m_lat.valid ? m_value() : 32'd0) || wb_data_s !== wb_data) begin
                errors++; $display("FAIL rnd_wb_data n %0d got %h/%h", n, wb_data, wb_data_s); end
            checks++; if (rs_data !== m_read(rs_addr) || rs_data_s !== m_read(rs_addr)) begin
                errors++; $display("FAIL rnd_rs n %0d got %h want %h", n, rs_data, m_read(rs_addr)); end
            checks++; if (rt_data !== m_read(rt_addr) || rt_data_s !== m_read(rt_addr)) begin
                errors++; $display("FAIL rnd_rt n %0d got %h want %h", n, rt_data, m_read(rt_addr)); end
            checks++; if (retired !== m_ret || retired_s !== m_ret[3:0]) begin
                errors++; $display("FAIL rnd_retired n %0d got %0d/%0d want %0d", n, retired, retired_s, m_ret); end
            tick();
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_counter_wrap();
        logic prev15 = 1'b0;
        logic wrapped = 1'b0;
        do_reset();
        for (int n = 0; n < 17; n++) begin
            drive(1'b1, 1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            tick();
            checks++; if (retired_s !== m_ret[3:0]) begin
                errors++; $display("FAIL wrap_seq n %0d got %0d want %0d", n, retired_s, m_ret[3:0]); end
            if (prev15 && retired_s == 4'd0) wrapped = 1'b1;
            prev15 = (retired_s == 4'd15);
        end
        bubble();
        tick();
        checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen got %b want 1", wrapped); end
        checks++; if (retired_s !== 4'd1) begin errors++; $display("FAIL wrap_end got %0d want 1", retired_s); end
        checks++; if (retired !== 32'd17) begin errors++; $display("FAIL wrap_wide got %0d want 17", retired); end
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        bubble();
        m_lat = '{valid: 1'b0, rw: 1'b0, sel: 2'd0, wr: 5'd0, alu: 32'd0, mem: 32'd0, pc: 32'd0};
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_ret = 32'd0;
        test_reset();
        test_alu_bypass();
        test_load_link_r0();
        test_stall();
        test_flush();
        test_random();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
